wbu: RTL and testbench
======================

// Module: wbu
// PURPOSE
//  Write-back stage, directly downstream of the load/store stage. Registers the lsu2wb_* bundle and
//  waits for the dmem response of loads/stores; aligns + sign/zero-extends load data. Drives the
//  register-file write port (also the forward source into the load/store stage) and retire pulse.
//  Stalls the pipe via wb2ac_hazard while a dmem response is outstanding.
// PARAMETERS
//  XLEN        32   datapath width; only 32 is supported
//  PC_RST      0    reset value of registered pc
// PORTS
//  clk                 in   1     clock
//  rstn                in   1     async active-low reset
//  lsu2wb_valid/pc/pc_plus/inst/rd/rf_we/rf_rd_sel1/dout/mem_valid/mem_byte_sel/mem_addr_offset
//                      in   -     load/store stage bundle (1/32/32/32/5/1/1/32/1/3/2)
//  dmem_resp_valid     in   1     data-memory response valid
//  dmem_resp_ready     out  1     wbu accepts response
//  dmem_resp           in   mem_resp_t  {resp_data[31:0], resp_err}
//  ac2wb_stall         in   1     hold pipeline register
//  ac2wb_flush         in   1     capture a bubble instead of lsu2wb bundle
//  wb2rf_wren          out  1     RF write enable
//  wb2rf_waddr         out  5     RF write address
//  wb2rf_wdata         out  32    RF write data
//  wb2ac_hazard        out  1     response outstanding; stall upstream
//  wb_retire_valid     out  1     one-cycle pulse per retired instruction
//  wb_retire_pc        out  32    pc of retiring instruction
//  wb2ac_bus_err       out  1     pulse: response carried resp_err
// BEHAVIOUR
//  - Reset: all regs 0 (pc=PC_RST), FSM=IDLE, all outputs 0, dmem_resp_ready=0.
//  - Capture: if ~ac2wb_stall & ~wb2ac_hazard: regs <= bundle; valid <= lsu2wb_valid & ~ac2wb_flush.
//  - mem op = valid & mem_valid; load = mem op & rf_rd_sel1. Response arrives >=1 cycle after capture.
//  - FSM IDLE: mem op captured & no resp this cycle -> WAIT. Resp in same cycle -> stays IDLE, completes.
//    WAIT: dmem_resp_ready=1, wb2ac_hazard=1; on dmem_resp_valid -> latch into resp buffer, -> IDLE.
//  - dmem_resp_ready = mem op & ~resp_buf_valid (never accepts a response with no owner).
//  - resp buffer holds data while ac2wb_stall keeps instruction in WB; cleared on next capture.
//  - Load align: sh = offset*8; byte: data>>sh [7:0]; half: data>>{offset[1],4'b0} [15:0]; word: full.
//    `MEM_BYTE/`MEM_HALF sign-extend, `MEM_BYTE_U/`MEM_HALF_U zero-extend (codes from macro.v).
//  - wb2rf_wdata = load ? aligned data : dout. wb2rf_wren = valid & rf_we & (rd!=0) & data available
//    (non-mem, or response accepted/buffered). Repeated writes during stall are idempotent, allowed.
//  - wb_retire_valid: valid & data available & ~ac2wb_stall, exactly once per instruction.
//  - resp_err: wb2ac_bus_err pulses 1 cycle with response; RF write suppressed; instruction still retires.
//  - Flush never cancels the instruction already in WB (its bus request is issued); only the capture.
//  - Reset mid-WAIT: FSM->IDLE immediately, buffer dropped; bus is reset on the same rstn.
// CONFIGURATION
//  URV_WB_MISALIGN_CHK_EN defined: adds out wb2ac_misalign (1): pulses at retire of a load with
//  half & offset[0]=1, or word & offset!=0; RF write suppressed for it. Undefined: port absent,
//  misaligned loads written with shifted data as above.
// STRUCTURE
//  - urv_typedef: mem_resp_t, wb_state_e {IDLE, WAIT}. macro.v: MEM_* byte-select codes.
//  - Sub-module load_align (combinational: data, byte_sel, offset -> 32b result); FSM/regs in wbu.
// TESTING
//  1 LW x5 addr 0x100, resp 0xDEADBEEF 1 cycle later -> wren, waddr=5, wdata=0xDEADBEEF, one retire.
//  2 LB offset 3, resp 0x80112233 -> wdata 0xFFFFFF80; LBU same -> 0x00000080; LHU off 2 -> 0x00008011.
//  3 LW, resp delayed 4 cycles -> hazard=1 for 4 cycles, ready=1 only then, no retire until resp.
//  4 resp arrives while ac2wb_stall=1 for 3 cycles -> buffered, data unchanged, single retire after.
//  5 ADD x0 / rf_we with rd=0 -> wren=0; flush on capture -> no retire; resp_err -> bus_err, wren=0.
//  6 rstn low in WAIT -> outputs 0, FSM IDLE; with URV_WB_MISALIGN_CHK_EN, LW off 2 -> misalign pulse.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared types and byte-select codes for the write-back stage.
// The byte-select codes mirror the MEM_* codes used by the load/store stage.
package wbu_pkg;

   localparam logic [2:0] MEM_BYTE   = 3'b000;
   localparam logic [2:0] MEM_HALF   = 3'b001;
   localparam logic [2:0] MEM_WORD   = 3'b010;
   localparam logic [2:0] MEM_BYTE_U = 3'b100;
   localparam logic [2:0] MEM_HALF_U = 3'b101;

   typedef struct packed {
      logic [31:0] resp_data;
      logic        resp_err;
   } mem_resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wb_state_e;

   typedef struct packed {
      wb_state_e   state;
      logic [31:0] inst;
      logic [31:0] pc_plus;
      logic        resp_buf_valid;
   } wb_dbg_t;

   function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
      logic res;
      case (sel)
         MEM_HALF, MEM_HALF_U: res = off[0];
         MEM_WORD:             res = (off != 2'b00);
         default:              res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/wbu_load_align.sv
// Combinational load aligner: shifts the response word by the address offset,
// then sign- or zero-extends according to the byte-select code.
module wbu_load_align
   import wbu_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  byte_sel,
   input  logic [1:0]  offset,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Half-word select uses only offset[1]; an odd offset still reads the enclosing half.
   assign byte_v = 8'(data >> {offset, 3'b000});
   assign half_v = 16'(data >> {offset[1], 4'b0000});

   always_comb begin
      result = data;
      case (byte_sel)
         MEM_BYTE:   result = {{24{byte_v[7]}}, byte_v};
         MEM_BYTE_U: result = {24'h0, byte_v};
         MEM_HALF:   result = {{16{half_v[15]}}, half_v};
         MEM_HALF_U: result = {16'h0, half_v};
         default:    result = data;
      endcase
   end

endmodule

// File: rtl/wbu.sv
// Write-back stage: registers the load/store bundle, waits for the dmem response,
// drives the RF write port and retire pulse. Define URV_WB_MISALIGN_CHK_EN to flag misaligned loads.
module wbu
   import wbu_pkg::*;
#(
   parameter int              XLEN   = 32,
   parameter logic [XLEN-1:0] PC_RST = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            lsu2wb_valid,
   input  logic [XLEN-1:0] lsu2wb_pc,
   input  logic [XLEN-1:0] lsu2wb_pc_plus,
   input  logic [31:0]     lsu2wb_inst,
   input  logic [4:0]      lsu2wb_rd,
   input  logic            lsu2wb_rf_we,
   input  logic            lsu2wb_rf_rd_sel1,
   input  logic [XLEN-1:0] lsu2wb_dout,
   input  logic            lsu2wb_mem_valid,
   input  logic [2:0]      lsu2wb_mem_byte_sel,
   input  logic [1:0]      lsu2wb_mem_addr_offset,
   input  logic            dmem_resp_valid,
   output logic            dmem_resp_ready,
   input  mem_resp_t       dmem_resp,
   input  logic            ac2wb_stall,
   input  logic            ac2wb_flush,
   output logic            wb2rf_wren,
   output logic [4:0]      wb2rf_waddr,
   output logic [XLEN-1:0] wb2rf_wdata,
   output logic            wb2ac_hazard,
   output logic            wb_retire_valid,
   output logic [XLEN-1:0] wb_retire_pc,
   output logic            wb2ac_bus_err,
`ifdef URV_WB_MISALIGN_CHK_EN
   output logic            wb2ac_misalign,
`endif
   output wb_dbg_t         wb_dbg
);

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_plus;
   logic [31:0]     r_inst;
   logic [4:0]      r_rd;
   logic            r_rf_we;
   logic            r_rd_sel1;
   logic [XLEN-1:0] r_dout;
   logic            r_mem_valid;
   logic [2:0]      r_byte_sel;
   logic [1:0]      r_offset;

   wb_state_e       state;
   logic            buf_valid;
   logic            buf_err;
   logic [31:0]     buf_data;
   logic            bus_err_q;

   logic            mem_op;
   logic            is_load;
   logic            data_avail;
   logic            capture;
   logic            resp_acc;
   logic            misalign;
   logic            suppress;
   logic [31:0]     load_data;

   assign mem_op     = r_valid & r_mem_valid;
   assign is_load    = mem_op & r_rd_sel1;
   assign data_avail = r_valid & (~r_mem_valid | buf_valid);

   // Handshake: a response transfers on a cycle where dmem_resp_valid and dmem_resp_ready
   // are both high. Ready is only offered while the instruction in WB owns an unanswered
   // request, and valid from the bus is ignored on every other cycle.
   assign dmem_resp_ready = mem_op & ~buf_valid;
   assign resp_acc        = dmem_resp_valid & dmem_resp_ready;

   assign wb2ac_hazard = (state == WAIT);
   assign capture      = ~ac2wb_stall & ~wb2ac_hazard;

`ifdef URV_WB_MISALIGN_CHK_EN
   assign misalign       = is_load & is_misaligned(r_byte_sel, r_offset);
   assign wb2ac_misalign = wb_retire_valid & misalign;
`else
   assign misalign = 1'b0;
`endif

   assign suppress        = (mem_op & buf_err) | misalign;
   assign wb2rf_wren      = data_avail & r_rf_we & (r_rd != 5'd0) & ~suppress;
   assign wb2rf_waddr     = r_rd;
   assign wb2rf_wdata     = is_load ? load_data : r_dout;
   assign wb_retire_valid = data_avail & ~ac2wb_stall;
   assign wb_retire_pc    = r_pc;
   assign wb2ac_bus_err   = bus_err_q;

   assign wb_dbg = '{state: state, inst: r_inst, pc_plus: r_pc_plus, resp_buf_valid: buf_valid};

   wbu_load_align u_align (
      .data     (buf_data),
      .byte_sel (r_byte_sel),
      .offset   (r_offset),
      .result   (load_data)
   );

   // WAIT is entered on the capture edge of a memory op, so the hazard is already up in
   // the first cycle the op sits in WB and no younger bundle can overwrite it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid     <= 1'b0;
         r_pc        <= PC_RST;
         r_pc_plus   <= '0;
         r_inst      <= '0;
         r_rd        <= '0;
         r_rf_we     <= 1'b0;
         r_rd_sel1   <= 1'b0;
         r_dout      <= '0;
         r_mem_valid <= 1'b0;
         r_byte_sel  <= '0;
         r_offset    <= '0;
         state       <= IDLE;
         buf_valid   <= 1'b0;
         buf_err     <= 1'b0;
         buf_data    <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         bus_err_q <= resp_acc & dmem_resp.resp_err;
         if (capture) begin
            r_valid     <= lsu2wb_valid & ~ac2wb_flush;
            r_pc        <= lsu2wb_pc;
            r_pc_plus   <= lsu2wb_pc_plus;
            r_inst      <= lsu2wb_inst;
            r_rd        <= lsu2wb_rd;
            r_rf_we     <= lsu2wb_rf_we;
            r_rd_sel1   <= lsu2wb_rf_rd_sel1;
            r_dout      <= lsu2wb_dout;
            r_mem_valid <= lsu2wb_mem_valid;
            r_byte_sel  <= lsu2wb_mem_byte_sel;
            r_offset    <= lsu2wb_mem_addr_offset;
            buf_valid   <= 1'b0;
            buf_err     <= 1'b0;
            state       <= (lsu2wb_valid & ~ac2wb_flush & lsu2wb_mem_valid) ? WAIT : IDLE;
         end else if (resp_acc) begin
            buf_valid <= 1'b1;
            buf_err   <= dmem_resp.resp_err;
            buf_data  <= dmem_resp.resp_data;
            state     <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed cases with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of retire order and RF writes.
module tb_wbu;
   import wbu_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        lsu2wb_valid, lsu2wb_rf_we, lsu2wb_rf_rd_sel1, lsu2wb_mem_valid;
   logic [31:0] lsu2wb_pc, lsu2wb_pc_plus, lsu2wb_inst, lsu2wb_dout;
   logic [4:0]  lsu2wb_rd;
   logic [2:0]  lsu2wb_mem_byte_sel;
   logic [1:0]  lsu2wb_mem_addr_offset;
   logic        dmem_resp_valid, dmem_resp_ready;
   mem_resp_t   dmem_resp;
   logic        ac2wb_stall, ac2wb_flush;
   logic        wb2rf_wren, wb2ac_hazard, wb_retire_valid, wb2ac_bus_err;
   logic [4:0]  wb2rf_waddr;
   logic [31:0] wb2rf_wdata, wb_retire_pc;
   wb_dbg_t     wb_dbg;
`ifdef URV_WB_MISALIGN_CHK_EN
   logic        wb2ac_misalign;
`endif

   wbu dut (
      .clk(clk), .rstn(rstn),
      .lsu2wb_valid(lsu2wb_valid), .lsu2wb_pc(lsu2wb_pc), .lsu2wb_pc_plus(lsu2wb_pc_plus),
      .lsu2wb_inst(lsu2wb_inst), .lsu2wb_rd(lsu2wb_rd), .lsu2wb_rf_we(lsu2wb_rf_we),
      .lsu2wb_rf_rd_sel1(lsu2wb_rf_rd_sel1), .lsu2wb_dout(lsu2wb_dout),
      .lsu2wb_mem_valid(lsu2wb_mem_valid), .lsu2wb_mem_byte_sel(lsu2wb_mem_byte_sel),
      .lsu2wb_mem_addr_offset(lsu2wb_mem_addr_offset),
      .dmem_resp_valid(dmem_resp_valid), .dmem_resp_ready(dmem_resp_ready), .dmem_resp(dmem_resp),
      .ac2wb_stall(ac2wb_stall), .ac2wb_flush(ac2wb_flush),
      .wb2rf_wren(wb2rf_wren), .wb2rf_waddr(wb2rf_waddr), .wb2rf_wdata(wb2rf_wdata),
      .wb2ac_hazard(wb2ac_hazard), .wb_retire_valid(wb_retire_valid), .wb_retire_pc(wb_retire_pc),
      .wb2ac_bus_err(wb2ac_bus_err),
`ifdef URV_WB_MISALIGN_CHK_EN
      .wb2ac_misalign(wb2ac_misalign),
`endif
      .wb_dbg(wb_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   typedef struct {
      logic [4:0]  rd;
      logic        rf_we, sel1, mem, err, flush, hang;
      logic [31:0] dout, rdata;
      logic [2:0]  sel;
      logic [1:0]  off;
      int          delay;
   } txn_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        wren;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        mis;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          delay;
   } rsp_t;

   exp_t        exp_q[$];
   rsp_t        resp_q[$];
   int          n_pass = 0, n_total = 0;
   int          ret_cnt = 0, dut_berr = 0, exp_berr = 0;
   int          hz_cur = 0, last_hz_run = 0, last_ready_cycles = 0, resp_wait = 0;
   logic [31:0] last_pc, last_wdata;
   logic [4:0]  last_waddr;
   logic        last_wren, last_mis;
   logic [31:0] pc_ctr = 32'h100;
   bit          rand_stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] sel,
                                            input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[int'(off) * 8 +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sel)
         MEM_BYTE:   return {{24{b[7]}}, b};
         MEM_BYTE_U: return {24'h0, b};
         MEM_HALF:   return {{16{h[15]}}, h};
         MEM_HALF_U: return {16'h0, h};
         default:    return w;
      endcase
   endfunction

   function automatic exp_t model(input txn_t t, input logic [31:0] pcv);
      exp_t e;
      logic ld, err, mis;
      ld  = t.mem && t.sel1;
      err = t.mem && t.err;
      mis = 1'b0;
`ifdef URV_WB_MISALIGN_CHK_EN
      mis = ld && ((((t.sel == MEM_HALF) || (t.sel == MEM_HALF_U)) && t.off[0]) ||
                   ((t.sel == MEM_WORD) && (t.off != 2'b00)));
`endif
      e.pc    = pcv;
      e.wren  = t.rf_we && (t.rd != 5'd0) && !err && !mis;
      e.waddr = t.rd;
      e.wdata = ld ? exp_load(t.rdata, t.sel, t.off) : t.dout;
      e.mis   = mis;
      return e;
   endfunction

   function automatic txn_t mk(input logic [4:0] rd, input logic rf_we, input logic mem,
                               input logic sel1, input logic [2:0] sel, input logic [1:0] off,
                               input logic [31:0] rdata, input int delay);
      txn_t t;
      t.rd = rd; t.rf_we = rf_we; t.mem = mem; t.sel1 = sel1; t.sel = sel; t.off = off;
      t.rdata = rdata; t.delay = delay; t.dout = $urandom;
      t.err = 1'b0; t.flush = 1'b0; t.hang = 1'b0;
      return t;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         lsu2wb_valid = 1'b0;
         ac2wb_flush  = 1'b0;
         ac2wb_stall  = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic issue(input txn_t t);
      bit          cap;
      int          guard;
      logic [31:0] pcv;
      rsp_t        r;
      pcv = pc_ctr;
      pc_ctr += 32'd4;
      @(negedge clk);
      lsu2wb_valid = 1'b1; lsu2wb_pc = pcv; lsu2wb_pc_plus = pcv + 32'd4; lsu2wb_inst = $urandom;
      lsu2wb_rd = t.rd; lsu2wb_rf_we = t.rf_we; lsu2wb_rf_rd_sel1 = t.sel1; lsu2wb_dout = t.dout;
      lsu2wb_mem_valid = t.mem; lsu2wb_mem_byte_sel = t.sel; lsu2wb_mem_addr_offset = t.off;
      ac2wb_flush = t.flush;
      cap = 0;
      guard = 0;
      while (!cap && guard < 200) begin
         if (rand_stall) ac2wb_stall = ($urandom_range(0, 3) == 0);
         cap = !ac2wb_stall && !wb2ac_hazard;
         @(posedge clk);
         if (!cap) @(negedge clk);
         guard++;
      end
      check("capture_timeout", 32'(cap), 32'd1);
      if (cap && !t.flush) begin
         exp_q.push_back(model(t, pcv));
         if (t.mem && !t.hang) begin
            r.data = t.rdata; r.err = t.err; r.delay = t.delay;
            resp_q.push_back(r);
            if (t.err) exp_berr++;
         end
      end
   endtask

   task automatic wait_ret(input int target);
      int n = 0;
      while (ret_cnt < target && n < 100) begin
         idle(1);
         n++;
      end
      check("retire_timeout", 32'(ret_cnt >= target), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wren"}, 32'(wb2rf_wren), 32'd0);
      check({tag, "_wdata"}, wb2rf_wdata, 32'd0);
      check({tag, "_retire"}, 32'(wb_retire_valid), 32'd0);
      check({tag, "_pc"}, wb_retire_pc, 32'd0);
      check({tag, "_hazard"}, 32'(wb2ac_hazard), 32'd0);
      check({tag, "_ready"}, 32'(dmem_resp_ready), 32'd0);
      check({tag, "_bus_err"}, 32'(wb2ac_bus_err), 32'd0);
      check({tag, "_state"}, 32'(wb_dbg.state), 32'(IDLE));
   endtask

   // ---------------- dmem responder ----------------
   initial begin
      dmem_resp_valid = 1'b0;
      dmem_resp       = '0;
      forever begin
         @(negedge clk);
         dmem_resp_valid = 1'b0;
         dmem_resp.resp_data = $urandom;
         dmem_resp.resp_err  = 1'($urandom_range(0, 1));
         if (rstn && dmem_resp_ready && resp_q.size() != 0) begin
            if (resp_wait == resp_q[0].delay) begin
               dmem_resp_valid     = 1'b1;
               dmem_resp.resp_data = resp_q[0].data;
               dmem_resp.resp_err  = resp_q[0].err;
               last_ready_cycles   = resp_wait + 1;
               void'(resp_q.pop_front());
               resp_wait = 0;
            end else begin
               resp_wait++;
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (!rstn) begin
            hz_cur = 0;
         end else begin
            if (wb2ac_hazard) hz_cur++;
            else if (hz_cur > 0) begin
               last_hz_run = hz_cur;
               hz_cur = 0;
            end
            if (wb2ac_bus_err) dut_berr++;
            if (wb2rf_wren) begin
               check("wren_owner", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  check("wren", 32'(wb2rf_wren), 32'(exp_q[0].wren));
                  check("waddr", 32'(wb2rf_waddr), 32'(exp_q[0].waddr));
                  check("wdata", wb2rf_wdata, exp_q[0].wdata);
               end
            end
            if (wb_retire_valid) begin
               check("retire_in_hazard", 32'(wb2ac_hazard), 32'd0);
               check("retire_owner", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("retire_pc", wb_retire_pc, e.pc);
                  check("retire_wren", 32'(wb2rf_wren), 32'(e.wren));
`ifdef URV_WB_MISALIGN_CHK_EN
                  check("misalign", 32'(wb2ac_misalign), 32'(e.mis));
                  last_mis = wb2ac_misalign;
`endif
                  last_pc = wb_retire_pc; last_wren = wb2rf_wren;
                  last_waddr = wb2rf_waddr; last_wdata = wb2rf_wdata;
                  ret_cnt++;
               end
            end
`ifdef URV_WB_MISALIGN_CHK_EN
            else if (wb2ac_misalign) check("misalign_idle", 32'(wb2ac_misalign), 32'd0);
`endif
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      txn_t        t;
      int          ret0, berr0, k;
      logic [31:0] pcv;
      logic [2:0]  sel;

      rstn = 1'b0;
      lsu2wb_valid = 0; lsu2wb_pc = 0; lsu2wb_pc_plus = 0; lsu2wb_inst = 0; lsu2wb_rd = 0;
      lsu2wb_rf_we = 0; lsu2wb_rf_rd_sel1 = 0; lsu2wb_dout = 0; lsu2wb_mem_valid = 0;
      lsu2wb_mem_byte_sel = 0; lsu2wb_mem_addr_offset = 0; ac2wb_stall = 0; ac2wb_flush = 0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rstn = 1'b1;

      // LW x5, response one cycle after capture
      ret0 = ret_cnt; pcv = pc_ctr;
      issue(mk(5'd5, 1'b1, 1'b1, 1'b1, MEM_WORD, 2'd0, 32'hDEADBEEF, 0));
      wait_ret(ret0 + 1);
      check("lw_wren", 32'(last_wren), 32'd1);
      check("lw_waddr", 32'(last_waddr), 32'd5);
      check("lw_wdata", last_wdata, 32'hDEADBEEF);
      check("lw_pc", last_pc, pcv);
      idle(3);
      check("lw_one_retire", 32'(ret_cnt - ret0), 32'd1);

      // byte / half alignment and extension
      ret0 = ret_cnt;
      issue(mk(5'd6, 1'b1, 1'b1, 1'b1, MEM_BYTE, 2'd3, 32'h80112233, 0));
      wait_ret(ret0 + 1);
      check("lb_wdata", last_wdata, 32'hFFFFFF80);
      issue(mk(5'd6, 1'b1, 1'b1, 1'b1, MEM_BYTE_U, 2'd3, 32'h80112233, 0));
      wait_ret(ret0 + 2);
      check("lbu_wdata", last_wdata, 32'h00000080);
      issue(mk(5'd6, 1'b1, 1'b1, 1'b1, MEM_HALF_U, 2'd2, 32'h80112233, 1));
      wait_ret(ret0 + 3);
      check("lhu_wdata", last_wdata, 32'h00008011);

      // response delayed: four hazard cycles, ready only while waiting
      ret0 = ret_cnt;
      issue(mk(5'd8, 1'b1, 1'b1, 1'b1, MEM_WORD, 2'd0, 32'h0BADF00D, 3));
      wait_ret(ret0 + 1);
      check("delay_hazard_cycles", 32'(last_hz_run), 32'd4);
      check("delay_ready_cycles", 32'(last_ready_cycles), 32'd4);
      check("delay_wdata", last_wdata, 32'h0BADF00D);

      // response lands while WB is stalled for three cycles
      ret0 = ret_cnt;
      issue(mk(5'd7, 1'b1, 1'b1, 1'b1, MEM_WORD, 2'd0, 32'h12345678, 0));
      @(negedge clk);
      lsu2wb_valid = 1'b0;
      ac2wb_stall  = 1'b1;
      repeat (3) @(negedge clk);
      check("stall_no_retire", 32'(ret_cnt - ret0), 32'd0);
      ac2wb_stall = 1'b0;
      wait_ret(ret0 + 1);
      check("stall_wdata", last_wdata, 32'h12345678);
      idle(3);
      check("stall_one_retire", 32'(ret_cnt - ret0), 32'd1);

      // ALU write to x0, flushed capture, bus error
      ret0 = ret_cnt;
      issue(mk(5'd0, 1'b1, 1'b0, 1'b0, MEM_WORD, 2'd0, 32'h0, 0));
      wait_ret(ret0 + 1);
      check("x0_wren", 32'(last_wren), 32'd0);
      ret0 = ret_cnt;
      t = mk(5'd3, 1'b1, 1'b0, 1'b0, MEM_WORD, 2'd0, 32'h0, 0);
      t.flush = 1'b1;
      issue(t);
      idle(4);
      check("flush_no_retire", 32'(ret_cnt - ret0), 32'd0);
      ret0 = ret_cnt; berr0 = dut_berr;
      t = mk(5'd9, 1'b1, 1'b1, 1'b1, MEM_WORD, 2'd0, 32'hAAAA5555, 1);
      t.err = 1'b1;
      issue(t);
      wait_ret(ret0 + 1);
      check("err_wren", 32'(last_wren), 32'd0);
      idle(2);
      check("err_bus_err_pulses", 32'(dut_berr - berr0), 32'd1);

`ifdef URV_WB_MISALIGN_CHK_EN
      ret0 = ret_cnt;
      issue(mk(5'd4, 1'b1, 1'b1, 1'b1, MEM_WORD, 2'd2, 32'hCAFEF00D, 0));
      wait_ret(ret0 + 1);
      check("misalign_pulse", 32'(last_mis), 32'd1);
      check("misalign_wren", 32'(last_wren), 32'd0);
`endif

      // reset while waiting for a response that never comes
      t = mk(5'd10, 1'b1, 1'b1, 1'b1, MEM_WORD, 2'd0, 32'h0, 0);
      t.hang = 1'b1;
      issue(t);
      idle(2);
      @(negedge clk);
      #2;
      check("hang_hazard", 32'(wb2ac_hazard), 32'd1);
      rstn = 1'b0;
      #1;
      check_reset_outputs("midwait");
      exp_q.delete();
      resp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      pc_ctr = 32'h1000;

      // randomized traffic with random stalls, flushes, errors and delays
      rand_stall = 1;
      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(0, 9);
         case ($urandom_range(0, 4))
            0:       sel = MEM_BYTE;
            1:       sel = MEM_HALF;
            2:       sel = MEM_WORD;
            3:       sel = MEM_BYTE_U;
            default: sel = MEM_HALF_U;
         endcase
         t = mk(($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                1'($urandom_range(0, 4) != 0), (k >= 4), (k < 8), sel,
                2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 4));
         t.err   = ($urandom_range(0, 7) == 0);
         t.flush = ($urandom_range(0, 7) == 0);
         issue(t);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      rand_stall = 0;
      idle(30);
      check("drain_exp_q", 32'(exp_q.size()), 32'd0);
      check("drain_resp_q", 32'(resp_q.size()), 32'd0);
      check("bus_err_total", 32'(dut_berr), 32'(exp_berr));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
